// File: rtl/bram_stream_reader.sv
// Streams len words out of a 2-cycle-latency BRAM into a valid/ready port; first word 4 cycles after start.
// Reads are credit-limited by FIFO space plus in-flight tags, so out_ready=0 stalls issue, never the return path.
module bram_stream_reader #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-2:0] len,
    output logic              busy,
    output logic              done,
    output logic              read_en,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int LEN_W = ADDR_W - 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  remaining;
    logic              done_zero;
    logic              s1_vld, s1_last, s2_vld, s2_last;

    logic [DATA_W-1:0] fifo_dat  [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  credit_used;

    logic issue, push, pop, drain_done, final_issue;

    // Credit ignores same-cycle pops; the s2 tag is already counted and moves into the FIFO this cycle.
    assign credit_used = fifo_count + CNT_W'(s1_vld) + CNT_W'(s2_vld);
    assign issue       = (state == ST_RUN) && (remaining != '0) &&
                         (credit_used < CNT_W'(FIFO_DEPTH));
    assign final_issue = issue && (remaining == LEN_W'(1));
    assign push        = s2_vld;
    assign pop         = out_valid && out_ready;
    assign drain_done  = (state == ST_DRAIN) && !s1_vld && !s2_vld && pop && out_last;

    assign busy      = (state != ST_IDLE);
    assign done      = done_zero || drain_done;
    assign read_en   = issue;
    assign read_addr = addr;
    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_dat[rd_ptr];
    assign out_last  = out_valid && fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            done_zero <= 1'b0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s2_vld    <= 1'b0;
            s2_last   <= 1'b0;
        end else begin
            done_zero <= 1'b0;
            s1_vld    <= issue;
            s1_last   <= final_issue;
            s2_vld    <= s1_vld;
            s2_last   <= s1_last;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            addr      <= base_addr & ~ADDR_W'(3);
                            remaining <= len;
                            state     <= ST_RUN;
                        end else begin
                            done_zero <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr      <= addr + ADDR_W'(4);
                        remaining <= remaining - LEN_W'(1);
                        if (final_issue) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat[wr_ptr]  <= read_val;
            fifo_last[wr_ptr] <= s2_last;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model with 2-cycle read latency, queue-based expected stream.
module tb_bram_stream_reader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-2:0] len;
    logic              busy, done, read_en;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] read_val;
    logic              out_valid, out_ready, out_last;
    logic [DATA_W-1:0] out_data;

    always #5 clk = ~clk;

    bram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .read_en(read_en), .read_addr(read_addr),
        .read_val(read_val), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // BRAM keeps running across DUT reset, so stale data can return after release.
    logic [31:0] mem [256];
    logic        p1_vld = 1'b0, p2_vld = 1'b0;
    logic [9:0]  p1_addr, p2_addr;
    logic [31:0] junk;
    always @(posedge clk) begin
        p1_vld  <= read_en;
        p1_addr <= read_addr;
        p2_vld  <= p1_vld;
        p2_addr <= p1_addr;
        junk    <= $urandom;
    end
    assign read_val = p2_vld ? mem[p2_addr[9:2]] : junk;

    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0]  exp_addr [$];
    logic [32:0] exp_word [$];
    logic        mon_en = 1'b0;
    int issued, accepted, done_cnt, done_rel, first_rd, first_ov, last_cnt, last_rel, issued_at19;
    logic        busy1;
    logic        hold_vld = 1'b0;
    logic        hold_last;
    logic [31:0] hold_data;

    always @(negedge clk) begin
        int rel;
        rel = cyc - start_cyc;
        if (!rst_n || !mon_en) begin
            hold_vld = 1'b0;
        end else begin
            if (rel == 1) busy1 = busy;
            if (rel == 19) issued_at19 = issued;
            if (read_en) begin
                check("read_pending", 64'(exp_addr.size() > 0), 1);
                if (exp_addr.size() > 0) check("read_addr", 64'(read_addr), 64'(exp_addr.pop_front()));
                check("credit", 64'((issued - accepted) < DEPTH), 1);
                if (first_rd < 0) first_rd = rel;
                issued++;
            end
            if (hold_vld)
                check("hold", {out_valid, out_last, out_data}, {1'b1, hold_last, hold_data});
            if (out_valid && first_ov < 0) first_ov = rel;
            if (out_valid && out_last) begin
                last_cnt++;
                last_rel = rel;
            end
            if (out_valid && out_ready) begin
                check("word_pending", 64'(exp_word.size() > 0), 1);
                if (exp_word.size() > 0) check("out_word", {out_last, out_data}, exp_word.pop_front());
                accepted++;
            end
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
            hold_vld  = out_valid && !out_ready;
            hold_last = out_last;
            hold_data = out_data;
        end
    end

    task automatic clear_model();
        exp_addr.delete();
        exp_word.delete();
        issued = 0; accepted = 0; done_cnt = 0; done_rel = -1;
        first_rd = -1; first_ov = -1; last_cnt = 0; last_rel = -1; issued_at19 = -1;
        busy1 = 1'bx;
    endtask

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'($urandom_range(0, 1));
        return (k >= 20);
    endfunction

    task automatic run_cmd(input logic [9:0] base, input int n, input int mode, input bit pulse);
        logic [9:0] a;
        for (int i = 0; i < n; i++) begin
            a = 10'((base & 10'h3FC) + 4 * i);
            exp_addr.push_back(a);
            exp_word.push_back({(i == n - 1), mem[a[9:2]]});
        end
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; len = 9'(n);
        out_ready = ready_for(mode, 0);
        start_cyc = cyc;
        for (int k = 1; k < 500 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            start = pulse && (k == 2);
            if (start) begin
                base_addr = 10'h200;
                len = 9'd7;
            end
            out_ready = ready_for(mode, k);
        end
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
        end
        check("done_count", 64'(done_cnt), 1);
        check("accepted", 64'(accepted), 64'(n));
        check("issued", 64'(issued), 64'(n));
        check("addr_left", 64'(exp_addr.size()), 0);
        check("word_left", 64'(exp_word.size()), 0);
        check("busy_after", 64'(busy), 0);
        check("busy_c1", 64'(busy1), 64'(n != 0));
    endtask

    task automatic cmd(input logic [9:0] base, input int n, input int mode, input bit pulse);
        clear_model();
        run_cmd(base, n, mode, pulse);
    endtask

    task automatic check_reset_state();
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_read_en", 64'(read_en), 0);
        check("rst_read_addr", 64'(read_addr), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out_last", 64'(out_last), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 expected finish earlier");
        $fatal(1);
    end

    initial begin
        foreach (mem[i]) mem[i] = $urandom;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
        clear_model();
        #2;
        check_reset_state();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        cmd(10'h010, 3, 0, 1'b0);
        check("t35_first_read", 64'(first_rd), 1);
        check("t35_first_valid", 64'(first_ov), 4);
        check("t35_done_cycle", 64'(done_rel), 6);
        check("t35_last_count", 64'(last_cnt), 1);
        check("t35_last_cycle", 64'(last_rel), 6);

        cmd(10'h123, 0, 0, 1'b0);
        check("t36_done_cycle", 64'(done_rel), 1);
        check("t36_no_read", 64'(first_rd), 64'(-1));
        check("t36_no_valid", 64'(first_ov), 64'(-1));

        cmd(10'h3F8, 4, 0, 1'b0);
        check("t37_done_cycle", 64'(done_rel), 7);

        cmd(10'h041, 8, 2, 1'b0);
        check("t38_reads_stalled", 64'(issued_at19), 4);
        check("t38_last_count", 64'(last_cnt), 1);

        // Abort a len=8 command by reset in its cycle 3.
        mon_en = 1'b0;
        clear_model();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h100; len = 9'd8; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_state();
        @(posedge clk); #1 rst_n = 1'b1;
        clear_model();
        mon_en = 1'b1;
        run_cmd(10'h020, 1, 0, 1'b0);
        check("t39_last_count", 64'(last_cnt), 1);

        cmd(10'h080, 5, 0, 1'b1);
        check("t40_done_cycle", 64'(done_rel), 8);

        for (int r = 0; r < 20; r++)
            cmd(10'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter: ADDR_W, 10, byte-address width of the BRAM read port.
REQ-002 Parameter: DATA_W, 32, word width.
REQ-003 Parameter: FIFO_DEPTH, 4, output buffer entries; power of two, minimum 4.
REQ-004 Port: clk  in  1  single clock; all logic is rising-edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: start  in  1  one-cycle command strobe; sampled only in IDLE.
REQ-007 Port: base_addr  in  ADDR_W  byte address of the first word; bits [1:0] are ignored (forced to 0).
REQ-008 Port: len  in  ADDR_W-1  number of words to read; 0 is legal.
REQ-009 Port: busy  out  1  high from the cycle after an accepted start until the cycle done is asserted.
REQ-010 Port: done  out  1  one-cycle pulse when a command completes.
REQ-011 Port: read_en  out  1  BRAM read strobe.
REQ-012 Port: read_addr  out  ADDR_W  BRAM byte address; the BRAM indexes words by read_addr>>2.
REQ-013 Port: read_val  in  DATA_W  BRAM data; valid exactly 2 cycles after the read_en cycle; don't-care otherwise.
REQ-014 Port: out_valid  out  1  stream word available.
REQ-015 Port: out_ready  in  1  stream consumer accepts.
REQ-016 Port: out_data  out  DATA_W  stream word.
REQ-017 Port: out_last  out  1  marks the final word of the command; qualified by out_valid.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN; the FSM shall be held in IDLE by reset.
REQ-019 In IDLE, start=1 with len>0 shall latch addr=base_addr&~3 and remaining=len, and transition to RUN.
REQ-020 In IDLE, start=1 with len=0 shall assert done in the next cycle, issue no reads and produce no stream words.
REQ-021 start while busy=1 shall be ignored.
REQ-022 In RUN, read_en shall be asserted in a cycle only if remaining>0 and fifo_count+inflight<FIFO_DEPTH; pops in the same cycle shall not count toward this (conservative credit).
REQ-023 Each issue shall drive read_addr=addr, then addr+=4 modulo 2^ADDR_W (wrap to 0 after the top word), and decrement remaining.
REQ-024 A 2-stage valid/last shift register shall track in-flight reads (inflight ≤ 2); read_val shall be written into the FIFO exactly in the cycle its tag exits stage 2, never at any other time.
REQ-025 The tag of the final issued read shall carry last=1, and that word shall present out_last=1.
REQ-026 When remaining reaches 0, the FSM shall move RUN→DRAIN.
REQ-027 DRAIN→IDLE shall occur when inflight=0 and the last word is accepted (out_valid&out_ready with out_last); done shall pulse in that same cycle.
REQ-028 FIFO: out_valid=(fifo_count>0); out_data/out_last shall be the head entry and shall stay stable while out_valid&!out_ready; a simultaneous push and pop shall leave the count unchanged.
REQ-029 FIFO overflow shall be impossible by construction (REQ-022); the FIFO shall not drop or stall the BRAM return path.
REQ-030 Timing: with start in cycle 0, read_en shall be first high in cycle 1 and out_valid first high in cycle 4.
REQ-031 With out_ready held at 1, one word per cycle shall be sustained (read_en continuously high for len cycles).
REQ-032 With out_ready=0, issue shall stop after fifo_count+inflight reaches FIFO_DEPTH; issue shall resume the cycle after credit frees.

Reset
REQ-033 rst_n low shall immediately clear: FSM=IDLE, busy=0, done=0, read_en=0, read_addr=0, out_valid=0, out_last=0, FIFO empty, in-flight tags cleared, remaining=0.
REQ-034 Reset mid-command shall abort the command; BRAM data returning after reset release shall be discarded, and no done shall be produced for the aborted command.

Verification
REQ-035 base_addr=0x010, len=3, out_ready=1 -> read_addr 0x010,0x014,0x018 in cycles 1-3; words for BRAM[4..6] on cycles 4-6; out_last only on cycle 6; done on cycle 6.
REQ-036 len=0 -> done in cycle 1; read_en and out_valid never high.
REQ-037 base_addr=0x3F8, len=4 -> read_addr 0x3F8,0x3FC,0x000,0x004; data order BRAM[254],[255],[0],[1].
REQ-038 len=8, out_ready=0 until cycle 20 -> exactly 4 reads issued, out_valid high with stable out_data; after out_ready=1, 8 words in order, done with the 8th.
REQ-039 rst_n low in cycle 3 of a len=8 command, start len=1 after release -> only the new word is output, exactly one done.
REQ-040 start pulsed during busy -> ignored; word count and addresses are those of the first command only.
